// File: rtl/onehot_sequencer.sv
// Registered index holder driving N one-hot or thermometer select lines, with
// up/down walking of the selected bit on a step strobe and wrap/error pulses.
module onehot_sequencer #(
    parameter int K = 6,
    parameter int N = 64
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         enable,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [K-1:0] in_idx,
    input  logic         step,
    output logic [N-1:0] out,
    output logic [K-1:0] out_idx,
    output logic         active,
    output logic         wrap,
    output logic         err
);

    localparam logic [K-1:0] LAST  = K'(N - 1);
    localparam logic [K:0]   N_EXT = (K+1)'(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state, state_d;
    logic [K-1:0] cur, cur_d;
    logic [N-1:0] out_d;
    logic         wrap_d, err_d;
    logic         accept;

    assign in_ready = enable;
    assign accept   = in_valid & enable;
    assign out_idx  = cur;
    assign active   = (state == HOLD);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            cur   <= '0;
            out   <= '0;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_d;
            cur   <= cur_d;
            out   <= out_d;
            wrap  <= wrap_d;
            err   <= err_d;
        end
    end

    // Accept has priority over step; wrap arithmetic is modulo N, not 2**K.
    always_comb begin
        state_d = state;
        cur_d   = cur;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (accept) begin
            if ({1'b0, in_idx} < N_EXT) begin
                cur_d   = in_idx;
                state_d = HOLD;
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end else if (enable && state == HOLD && step) begin
            if (mode == 2'b01) begin
                if (cur == LAST) begin
                    cur_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cur_d = cur + K'(1);
                end
            end else if (mode == 2'b10) begin
                if (cur == '0) begin
                    cur_d  = LAST;
                    wrap_d = 1'b1;
                end else begin
                    cur_d = cur - K'(1);
                end
            end
        end
    end

    // Output is encoded from next-state values so it lines up with out_idx.
    always_comb begin
        out_d = '0;
        if (enable && state_d == HOLD) begin
            for (int i = 0; i < N; i++) begin
                if (mode == 2'b11) out_d[i] = (K'(i) <= cur_d);
                else               out_d[i] = (K'(i) == cur_d);
            end
        end
    end

endmodule

// File: tb/tb_onehot_sequencer.sv
// Bench for onehot_sequencer: a 64-line and a 40-line instance share stimulus and
// are compared against a behavioural model, a vector table and hand sequences.
module tb_onehot_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  md;
    logic        vld;
    logic [5:0]  idx;
    logic        stp;

    logic        rdy_a, rdy_b;
    logic [63:0] out_a;
    logic [39:0] out_b;
    logic [5:0]  oidx_a, oidx_b;
    logic        act_a, act_b, wrap_a, wrap_b, err_a, err_b;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    onehot_sequencer #(.K(6), .N(64)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(en), .mode(md),
        .in_valid(vld), .in_ready(rdy_a), .in_idx(idx), .step(stp),
        .out(out_a), .out_idx(oidx_a), .active(act_a), .wrap(wrap_a), .err(err_a)
    );

    onehot_sequencer #(.K(6), .N(40)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(en), .mode(md),
        .in_valid(vld), .in_ready(rdy_b), .in_idx(idx), .step(stp),
        .out(out_b), .out_idx(oidx_b), .active(act_b), .wrap(wrap_b), .err(err_b)
    );

    // Reference model state, one slot per instance.
    int          mn [2] = '{64, 40};
    int          m_cur [2];
    bit          m_act [2];
    bit          m_wrap [2];
    bit          m_err [2];
    logic [63:0] m_out [2];

    typedef struct {
        logic        en;
        logic [1:0]  md;
        logic        vld;
        logic [5:0]  idx;
        logic        stp;
        logic [5:0]  e_idx;
        logic        e_act;
        logic        e_wrap;
        logic        e_err;
        logic [63:0] e_out;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(logic e, logic [1:0] m, logic v, logic [5:0] ix, logic s,
                                logic [5:0] ei, logic ea, logic ew, logic ee, logic [63:0] eo);
        vec_t r;
        r.en = e; r.md = m; r.vld = v; r.idx = ix; r.stp = s;
        r.e_idx = ei; r.e_act = ea; r.e_wrap = ew; r.e_err = ee; r.e_out = eo;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, got, want);
    endtask

    function automatic logic [63:0] encode(int cur, logic [1:0] m);
        logic [64:0] t;
        if (m == 2'd3) begin
            t = (65'd1 << (cur + 1)) - 65'd1;
            return t[63:0];
        end
        return 64'd1 << cur;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_cur[p] = 0; m_act[p] = 0; m_wrap[p] = 0; m_err[p] = 0; m_out[p] = '0;
        end
    endtask

    task automatic model_edge();
        for (int p = 0; p < 2; p++) begin
            m_wrap[p] = 0;
            m_err[p]  = 0;
            if (en) begin
                if (vld) begin
                    if (int'(idx) < mn[p]) begin
                        m_cur[p] = int'(idx);
                        m_act[p] = 1;
                    end else begin
                        m_act[p] = 0;
                        m_err[p] = 1;
                    end
                end else if (m_act[p] && stp && md == 2'd1) begin
                    m_wrap[p] = (m_cur[p] == mn[p] - 1);
                    m_cur[p]  = (m_cur[p] + 1) % mn[p];
                end else if (m_act[p] && stp && md == 2'd2) begin
                    m_wrap[p] = (m_cur[p] == 0);
                    m_cur[p]  = (m_cur[p] + mn[p] - 1) % mn[p];
                end
                m_out[p] = m_act[p] ? encode(m_cur[p], md) : 64'd0;
            end else begin
                m_out[p] = '0;
            end
        end
    endtask

    task automatic check_model();
        check("model out64",     out_a,              m_out[0]);
        check("model out40",     {24'd0, out_b},     m_out[1]);
        check("model out_idx64", 64'(oidx_a),        64'(m_cur[0]));
        check("model out_idx40", 64'(oidx_b),        64'(m_cur[1]));
        check("model active64",  64'(act_a),         64'(m_act[0]));
        check("model active40",  64'(act_b),         64'(m_act[1]));
        check("model wrap64",    64'(wrap_a),        64'(m_wrap[0]));
        check("model wrap40",    64'(wrap_b),        64'(m_wrap[1]));
        check("model err64",     64'(err_a),         64'(m_err[0]));
        check("model err40",     64'(err_b),         64'(m_err[1]));
        check("model in_ready",  64'({rdy_a, rdy_b}), 64'({en, en}));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(logic e, logic [1:0] m, logic v, logic [5:0] ix, logic s);
        en = e; md = m; vld = v; idx = ix; stp = s;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 6'd0, 1'b0);
        model_reset();

        // Reset values and in_ready tracking enable during reset.
        #12;
        check("reset out",     out_a,         64'd0);
        check("reset out_idx", 64'(oidx_a),   64'd0);
        check("reset active",  64'(act_a),    64'd0);
        check("reset wrap",    64'(wrap_a),   64'd0);
        check("reset err",     64'(err_a),    64'd0);
        check("reset rdy_lo",  64'(rdy_a),    64'd0);
        en = 1'b1;
        #1;
        check("reset rdy_hi",  64'(rdy_a),    64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Vector table, expectations for the 64-line instance.
        tbl[0]  = mk(1'b1, 2'd0, 1'b1, 6'd5,  1'b0, 6'd5,  1'b1, 1'b0, 1'b0, 64'h20);
        tbl[1]  = mk(1'b1, 2'd1, 1'b1, 6'd62, 1'b0, 6'd62, 1'b1, 1'b0, 1'b0, 64'd1 << 62);
        tbl[2]  = mk(1'b1, 2'd1, 1'b0, 6'd0,  1'b1, 6'd63, 1'b1, 1'b0, 1'b0, 64'd1 << 63);
        tbl[3]  = mk(1'b1, 2'd1, 1'b0, 6'd0,  1'b1, 6'd0,  1'b1, 1'b1, 1'b0, 64'd1);
        tbl[4]  = mk(1'b1, 2'd1, 1'b0, 6'd0,  1'b1, 6'd1,  1'b1, 1'b0, 1'b0, 64'd2);
        tbl[5]  = mk(1'b1, 2'd2, 1'b0, 6'd0,  1'b1, 6'd0,  1'b1, 1'b0, 1'b0, 64'd1);
        tbl[6]  = mk(1'b1, 2'd2, 1'b0, 6'd0,  1'b1, 6'd63, 1'b1, 1'b1, 1'b0, 64'd1 << 63);
        tbl[7]  = mk(1'b1, 2'd1, 1'b1, 6'd10, 1'b0, 6'd10, 1'b1, 1'b0, 1'b0, 64'd1 << 10);
        tbl[8]  = mk(1'b1, 2'd1, 1'b1, 6'd3,  1'b1, 6'd3,  1'b1, 1'b0, 1'b0, 64'd1 << 3);
        tbl[9]  = mk(1'b1, 2'd0, 1'b1, 6'd7,  1'b0, 6'd7,  1'b1, 1'b0, 1'b0, 64'd1 << 7);
        tbl[10] = mk(1'b0, 2'd1, 1'b1, 6'd2,  1'b1, 6'd7,  1'b1, 1'b0, 1'b0, 64'd0);
        tbl[11] = mk(1'b0, 2'd1, 1'b0, 6'd0,  1'b1, 6'd7,  1'b1, 1'b0, 1'b0, 64'd0);
        tbl[12] = mk(1'b1, 2'd0, 1'b0, 6'd0,  1'b0, 6'd7,  1'b1, 1'b0, 1'b0, 64'd1 << 7);
        tbl[13] = mk(1'b1, 2'd3, 1'b0, 6'd0,  1'b0, 6'd7,  1'b1, 1'b0, 1'b0, 64'hFF);
        tbl[14] = mk(1'b1, 2'd0, 1'b0, 6'd0,  1'b1, 6'd7,  1'b1, 1'b0, 1'b0, 64'd1 << 7);
        tbl[15] = mk(1'b1, 2'd3, 1'b1, 6'd63, 1'b0, 6'd63, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].md, tbl[i].vld, tbl[i].idx, tbl[i].stp);
            tick();
            check($sformatf("vec%0d out", i),     out_a,        tbl[i].e_out);
            check($sformatf("vec%0d out_idx", i), 64'(oidx_a),  64'(tbl[i].e_idx));
            check($sformatf("vec%0d active", i),  64'(act_a),   64'(tbl[i].e_act));
            check($sformatf("vec%0d wrap", i),    64'(wrap_a),  64'(tbl[i].e_wrap));
            check($sformatf("vec%0d err", i),     64'(err_a),   64'(tbl[i].e_err));
            check($sformatf("vec%0d in_ready", i), 64'(rdy_a),  64'(tbl[i].en));
        end

        // Thermometer on the 40-line instance, then out-of-range accepts back to back.
        drive(1'b1, 2'd3, 1'b1, 6'd39, 1'b0);
        tick();
        check("therm40 all ones", 64'(out_b), 64'hFF_FFFF_FFFF);
        idx = 6'd40;
        tick();
        check("oor err",     64'(err_b),  64'd1);
        check("oor active",  64'(act_b),  64'd0);
        check("oor out",     64'(out_b),  64'd0);
        check("oor out_idx", 64'(oidx_b), 64'd39);
        tick();
        check("oor err again", 64'(err_b), 64'd1);
        drive(1'b1, 2'd1, 1'b0, 6'd0, 1'b1);
        tick();
        check("err clears",   64'(err_b),  64'd0);
        check("idle no step", 64'(oidx_b), 64'd39);
        check("idle no wrap", 64'(wrap_b), 64'd0);

        // Asynchronous reset between edges while holding 20 in scan-up.
        drive(1'b1, 2'd1, 1'b1, 6'd20, 1'b0);
        tick();
        check("hold20 out", out_a, 64'd1 << 20);
        drive(1'b1, 2'd1, 1'b0, 6'd0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("async out",     out_a,       64'd0);
        check("async out_idx", 64'(oidx_a), 64'd0);
        check("async active",  64'(act_a),  64'd0);
        check("async wrap",    64'(wrap_a), 64'd0);
        check("async err",     64'(err_a),  64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) == 0), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/onehot_sequencer.md
# onehot_sequencer

Registered, parametrised successor to the team's combinational binary-to-one-hot decoder. It accepts an index over a valid/ready handshake and holds it. It drives a registered N-bit one-hot or thermometer select, and can walk the selected bit up or down on a step strobe, flagging wrap-around. It sits in the user project area and drives per-channel select lines, such as column or enable lines, from a single index source.

## Interface
- K, default 6: index width in bits.
- N, default 64: number of output lines; legal range 2 ≤ N ≤ 2**K. An index ≥ N is out of range.
- wb_clk_i  in  1  clock; all state changes on the rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- enable  in  1  global enable; low blanks the outputs and freezes the state.
- mode  in  2  00 decode, 01 scan-up, 10 scan-down, 11 thermometer.
- in_valid  in  1  index offered.
- in_ready  out  1  block can accept an index; combinational, equal to enable.
- in_idx  in  K  offered index.
- step  in  1  advance the walking bit; acts in scan modes only.
- out  out  N  registered select lines.
- out_idx  out  K  registered current index.
- active  out  1  registered; high when a legal index is held.
- wrap  out  1  registered one-cycle pulse on scan wrap-around.
- err  out  1  registered one-cycle pulse when an out-of-range index is accepted.

## Operation
- **State:** cur[K-1:0] and a 2-state FSM. IDLE means active=0. HOLD means active=1.
- **Accept:** a transfer happens when in_valid & in_ready. On an accepted transfer:
  - If in_idx < N: cur ← in_idx, go to HOLD.
  - If in_idx ≥ N: go to IDLE, cur unchanged, err pulses.
- **Priority:** accept beats step in the same cycle; that step is discarded.
- **Step** is honoured only when enable=1, in HOLD, with mode 01 or 10, and no accept in that cycle. Step in IDLE, in mode 00 or 11, or with enable=0 is ignored.
  - Scan-up: cur ← cur+1. If cur == N-1, cur ← 0 and wrap pulses.
  - Scan-down: cur ← cur-1. If cur == 0, cur ← N-1 and wrap pulses.
  - Arithmetic is modulo N, not 2**K.
- **Output encoding** is a function of the next-state values:
  - If enable=0 or IDLE: out = 0.
  - Modes 00, 01, 10: out[i] = (i == cur).
  - Mode 11: out[i] = (i ≤ cur), so cur = N-1 gives all ones.
- **Mode changes** take effect at the next edge. cur and the FSM state are kept. The output re-encodes at that edge with no extra delay.
- **enable low:** in_ready=0, out ← 0 at the next edge, and cur, active, and the FSM are held. When enable rises again, out shows the held index at the next edge.
- out_idx always equals cur.

## Timing
- **Reset values** (asynchronous, immediate): out=0, out_idx=0, cur=0, active=0, wrap=0, err=0, FSM=IDLE. in_ready follows enable even during reset.
- **Release:** the first edge with wb_rst_i=0 is a normal cycle.
- **Latency:** 1 cycle. An accept or step sampled at edge E is visible on out, out_idx, and active just after E.
- **Pulses:** wrap and err are high for exactly the cycle after the causing edge, then return to 0. Back-to-back causes give back-to-back pulses.
- **Throughput:** one accept or one step per cycle; no bubbles.
- **Reset mid-operation:** all registers clear immediately. A pending accept or step in that cycle is lost.

## Test plan
- **Reset/decode:** assert reset, then release; enable=1, mode=00, accept in_idx=5. Next cycle: out=64'h20, out_idx=5, active=1, err=0.
- **Scan wrap:** mode=01, accept 62, then step ×3. Expect out_idx 63, 0 (wrap=1 that cycle only), 1. Then mode=10 and step ×2: expect 0, 63 (wrap=1).
- **Thermometer/non-power-of-2:** N=40, K=6, mode=11, accept 39 → out all 40 ones. Accept 40 → err=1 for one cycle, active=0, out=0, out_idx stays 39.
- **Simultaneous events:** mode=01 holding 10; in the same cycle in_valid=1, in_idx=3, step=1. Expect out_idx=3 and no increment.
- **Enable gating:** hold 7, drop enable. Next cycle out=0, in_ready=0, active=1; step and in_valid are ignored. Raise enable: the next cycle shows out[7]=1.
- **Async reset mid-scan:** assert wb_rst_i between edges while holding 20. out and out_idx go to 0 before the next edge; wrap and err stay 0.
